// File: rtl/md_unit_sched.sv
// md_unit_sched: E-stage multiply/divide unit with fixed-latency busy window.
// Results are computed at the start edge into pending registers and committed
// to HI/LO on the last busy cycle; the D-stage stall hides the latency.
module md_unit_sched #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        E_valid,
  input  logic [3:0]  E_mdOp,
  input  logic [31:0] E_rs,
  input  logic [31:0] E_rt,
  input  logic        D_isMd,
  output logic        busy,
  output logic        D_stallReq,
  output logic [31:0] E_mdOut,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0]   pend_hi, pend_lo;
  logic          pend_ok;

  logic is_md, is_mul, is_div, start, commit, idle;
  logic [63:0] smul, umul;
  logic [31:0] dsr, ua, ub, uq, ur, sq, sr, dq, dr;

  assign is_mul = (E_mdOp == 4'd1) || (E_mdOp == 4'd2);
  assign is_div = (E_mdOp == 4'd3) || (E_mdOp == 4'd4);
  assign is_md  = is_mul || is_div;
  assign idle   = (state == IDLE);
  assign start  = E_valid && is_md && idle;
  assign busy   = !idle;
  assign commit = busy && (cnt == '0);

  assign D_stallReq = D_isMd && (busy || (E_valid && is_md));

  // mfhi/mflo read the current architectural value; everything else reads 0
  always_comb begin
    E_mdOut = '0;
    if (E_valid && E_mdOp == 4'd7) E_mdOut = hi;
    if (E_valid && E_mdOp == 4'd8) E_mdOut = lo;
  end

  // Arithmetic: signed divide via magnitudes so -2^31/-1 wraps deterministically;
  // a zero divisor is replaced by 1 only to keep the datapath X-free (no commit).
  always_comb begin
    smul = $signed({{32{E_rs[31]}}, E_rs}) * $signed({{32{E_rt[31]}}, E_rt});
    umul = {32'b0, E_rs} * {32'b0, E_rt};
    dsr  = (E_rt == '0) ? 32'd1 : E_rt;
    dq   = E_rs / dsr;
    dr   = E_rs % dsr;
    ua   = E_rs[31] ? (-E_rs) : E_rs;
    ub   = dsr[31] ? (-dsr) : dsr;
    uq   = ua / ub;
    ur   = ua % ub;
    sq   = (E_rs[31] ^ dsr[31]) ? (-uq) : uq;
    sr   = E_rs[31] ? (-ur) : ur;
  end

  // FSM state and latency counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state: load the counter at start, count down, return to IDLE at zero
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (start && is_mul) begin
          state_n = MUL;
          cnt_n   = CW'(MULT_LAT - 1);
        end else if (start && is_div) begin
          state_n = DIV;
          cnt_n   = CW'(DIV_LAT - 1);
        end
      end
      MUL, DIV: begin
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Pending results captured at start; HI/LO written by commit or mthi/mtlo
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_hi <= '0;
      pend_lo <= '0;
      pend_ok <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else if (start) begin
      pend_ok <= !(is_div && E_rt == '0);
      case (E_mdOp)
        4'd1:    begin pend_hi <= smul[63:32]; pend_lo <= smul[31:0]; end
        4'd2:    begin pend_hi <= umul[63:32]; pend_lo <= umul[31:0]; end
        4'd3:    begin pend_hi <= sr;          pend_lo <= sq;         end
        default: begin pend_hi <= dr;          pend_lo <= dq;         end
      endcase
    end else if (commit) begin
      if (pend_ok) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else if (idle && E_valid) begin
      if (E_mdOp == 4'd5) hi <= E_rs;
      if (E_mdOp == 4'd6) lo <= E_rs;
    end
  end

endmodule

// File: doc/md_unit_sched.md
Name: md_unit_sched

Overview:
- Multiply/divide unit and scheduler for the E stage of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from the E stage, sequences a fixed-latency busy window, and commits HI/LO at the end of it.
- Generates the D-stage stall request that holds the pipeline until the result is ready, so the hazard logic need not model MDU latency.

Parameters:
- MULT_LAT, 5, busy cycles for mult/multu (>=1).
- DIV_LAT, 10, busy cycles for div/divu (>=1).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- E_valid  in  1  E-stage instruction is real (not bubble/flushed).
- E_mdOp  in  4  op code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 treated as none.
- E_rs  in  32  forwarded rs operand.
- E_rt  in  32  forwarded rt operand.
- D_isMd  in  1  D-stage instruction is any of ops 1-8.
- busy  out  1  MDU executing mult/div.
- D_stallReq  out  1  stall request to the hazard unit.
- E_mdOut  out  32  mfhi/mflo result for the E-stage result mux.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0, hi=0, lo=0, pending HI/LO=0, busy=0. E_mdOut and D_stallReq are driven only by combinational terms that evaluate to 0 under reset state with D_isMd=0. Reset mid-operation aborts the op; HI/LO stay 0.
- Start is defined as: E_valid=1, op in 1-4, state=IDLE.
- FSM states: IDLE, MUL, DIV.
  - IDLE -> MUL on start with op 1/2; counter loads MULT_LAT-1.
  - IDLE -> DIV on start with op 3/4; counter loads DIV_LAT-1.
  - MUL/DIV: counter decrements each cycle. When counter==0, the edge commits pending HI/LO to hi/lo and the FSM returns to IDLE.
- Results are computed at the start edge into pending registers:
  - mult: signed 32x32->64, HI=[63:32], LO=[31:0].
  - multu: unsigned 32x32->64, same split.
  - div: signed; LO=quotient truncated toward zero, HI=remainder with sign of dividend. Dividend is E_rs, divisor is E_rt.
  - divu: unsigned; LO=quotient, HI=remainder.
  - div/divu with E_rt==0: timing unchanged, but no commit; hi/lo keep their prior values.
- busy=1 exactly in states MUL/DIV.
- Latency: start at edge T gives busy=1 for cycles T+1..T+LAT. hi/lo are updated at the edge ending cycle T+LAT and are visible with busy=0 from cycle T+LAT+1.
- mthi/mtlo (E_valid=1, state=IDLE): hi (or lo) <= E_rs at the next edge. When issued while busy, the op is ignored; the stall makes this unreachable in legal operation.
- mfhi/mflo: E_mdOut = hi or lo combinationally (current architectural value). E_mdOut=0 for all other ops.
- D_stallReq = D_isMd & (busy | (E_valid & E_mdOp in 1-4)). This covers the start cycle itself.
  - Non-MD D-stage instructions never stall on the MDU.
  - E-stage mfhi/mflo never stall, because the D stall guarantees no mult/div is in flight.
- Start while busy: ignored; pending registers and counter are not disturbed.
- E_valid=0: the op is ignored entirely, whatever the value of E_mdOp.
- Last busy cycle followed by a new start on the next cycle (back-to-back): permitted. The new start uses the committed hi/lo only through operands; operands come from E_rs/E_rt.

Test Plan:
1. mult, E_rs=0x00000003, E_rt=0xFFFFFFFE -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
2. multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA after 5 busy cycles. D_isMd=1 during the start cycle and busy cycles -> D_stallReq=1 for 6 cycles; D_isMd=0 -> D_stallReq=0.
3. div, E_rs=0xFFFFFFF9 (-7), E_rt=2 -> 10 busy cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/2 -> lo=3, hi=1.
4. hi=0x12345678 via mthi; lo=0x9ABCDEF0 via mtlo; then divu with E_rt=0 -> 10 busy cycles, hi/lo unchanged. mfhi -> E_mdOut=0x12345678; mflo -> E_mdOut=0x9ABCDEF0.
5. Start mult, then drive rst_n=0 in busy cycle 3 -> busy, hi, lo=0 immediately (asynchronously); no commit after rst_n is released.
6. Start mult with E_valid=0 -> no busy. Start mult, then attempt mthi with E_rs=0xFFFFFFFF in busy cycle 2 -> mthi ignored; hi equals the mult result.
